// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_loader
// Purpose  : Builds 32-bit MIPS instruction words from symbolic fields taken
//            over a valid/ready handshake and writes them into instruction
//            memory at consecutive word addresses from a programmable base.
//            Optional macro DELAY_SLOT_NOP_EN appends a NOP after every
//            branch/jump word.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              full,
    output logic              err_illegal,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] c_last_addr = '1;
    localparam logic [ADDR_W-1:0] c_addr_one  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   c_cnt_one   = {{ADDR_W{1'b0}}, 1'b1};

    localparam logic [1:0] c_fmt_r = 2'd0;
    localparam logic [1:0] c_fmt_i = 2'd1;
    localparam logic [1:0] c_fmt_j = 2'd2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ACCEPT    = 3'd1,
        WRITE     = 3'd2,
`ifdef DELAY_SLOT_NOP_EN
        WRITE_NOP = 3'd4,
`endif
        FULL      = 3'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [5:0]  w_opc;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_sh;
    logic [5:0]  w_fn;
    logic [1:0]  w_fmt;
    logic        w_legal;
    logic [31:0] w_word;

`ifdef DELAY_SLOT_NOP_EN
    logic        w_branch;
    logic        r_is_branch;
    assign w_branch = (op_sel == 6'd16) || ((op_sel >= 6'd27) && (op_sel <= 6'd33));
`endif

    // Field encoder: pick opcode/funct and zero every field the instruction does not use
    always_comb begin
        w_opc   = 6'h00;
        w_rs    = rs;
        w_rt    = rt;
        w_rd    = rd;
        w_sh    = 5'd0;
        w_fn    = 6'h00;
        w_fmt   = c_fmt_r;
        w_legal = 1'b1;
        case (op_sel)
            6'd0:  w_fn = 6'h20;
            6'd1:  w_fn = 6'h21;
            6'd2:  w_fn = 6'h22;
            6'd3:  w_fn = 6'h23;
            6'd4:  w_fn = 6'h24;
            6'd5:  w_fn = 6'h25;
            6'd6:  w_fn = 6'h26;
            6'd7:  w_fn = 6'h27;
            6'd8:  w_fn = 6'h2A;
            6'd9:  w_fn = 6'h2B;
            6'd10: begin w_rs = 5'd0; w_sh = shamt; w_fn = 6'h00; end
            6'd11: begin w_rs = 5'd0; w_sh = shamt; w_fn = 6'h02; end
            6'd12: begin w_rs = 5'd0; w_sh = shamt; w_fn = 6'h03; end
            6'd13: w_fn = 6'h04;
            6'd14: w_fn = 6'h06;
            6'd15: w_fn = 6'h07;
            6'd16: begin w_rt = 5'd0; w_rd = 5'd0; w_fn = 6'h08; end
            6'd17: begin w_fmt = c_fmt_i; w_opc = 6'h08; end
            6'd18: begin w_fmt = c_fmt_i; w_opc = 6'h09; end
            6'd19: begin w_fmt = c_fmt_i; w_opc = 6'h0C; end
            6'd20: begin w_fmt = c_fmt_i; w_opc = 6'h0D; end
            6'd21: begin w_fmt = c_fmt_i; w_opc = 6'h0E; end
            6'd22: begin w_fmt = c_fmt_i; w_opc = 6'h0A; end
            6'd23: begin w_fmt = c_fmt_i; w_opc = 6'h0B; end
            6'd24: begin w_fmt = c_fmt_i; w_opc = 6'h0F; w_rs = 5'd0; end
            6'd25: begin w_fmt = c_fmt_i; w_opc = 6'h23; end
            6'd26: begin w_fmt = c_fmt_i; w_opc = 6'h2B; end
            6'd27: begin w_fmt = c_fmt_i; w_opc = 6'h04; end
            6'd28: begin w_fmt = c_fmt_i; w_opc = 6'h05; end
            6'd29: begin w_fmt = c_fmt_i; w_opc = 6'h06; w_rt = 5'd0; end
            6'd30: begin w_fmt = c_fmt_i; w_opc = 6'h07; w_rt = 5'd0; end
            6'd31: begin w_fmt = c_fmt_i; w_opc = 6'h01; w_rt = 5'd0; end
            6'd32: begin w_fmt = c_fmt_i; w_opc = 6'h01; w_rt = 5'd1; end
            6'd33: begin w_fmt = c_fmt_j; w_opc = 6'h02; end
            6'd34: begin w_opc = 6'h1C; w_fn = 6'h20; end
            6'd35: begin w_opc = 6'h1C; w_fn = 6'h21; end
            default: w_legal = 1'b0;
        endcase
    end

    // Word assembly from the selected instruction format
    always_comb begin
        w_word = 32'd0;
        case (w_fmt)
            c_fmt_i: w_word = {w_opc, w_rs, w_rt, imm};
            c_fmt_j: w_word = {w_opc, target};
            default: w_word = {w_opc, w_rs, w_rt, w_rd, w_sh, w_fn};
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and Moore outputs; finish wins over a same-cycle in_valid
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        im_we    = 1'b0;
        busy     = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (start) state_d = ACCEPT;
            end
            ACCEPT: begin
                in_ready = 1'b1;
                if (finish)                   state_d = IDLE;
                else if (in_valid && w_legal) state_d = WRITE;
            end
            WRITE: begin
                im_we = 1'b1;
                if (im_addr == c_last_addr) state_d = FULL;
`ifdef DELAY_SLOT_NOP_EN
                else if (r_is_branch)       state_d = WRITE_NOP;
`endif
                else                        state_d = ACCEPT;
            end
`ifdef DELAY_SLOT_NOP_EN
            WRITE_NOP: begin
                im_we = 1'b1;
                if (im_addr == c_last_addr) state_d = FULL;
                else                        state_d = ACCEPT;
            end
`endif
            FULL: begin
                if (finish) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: session address/count, latched word, full flag and error pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            im_addr     <= '0;
            im_wdata    <= 32'd0;
            full        <= 1'b0;
            err_illegal <= 1'b0;
            word_count  <= '0;
`ifdef DELAY_SLOT_NOP_EN
            r_is_branch <= 1'b0;
`endif
        end else begin
            err_illegal <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        im_addr    <= base_addr;
                        word_count <= '0;
                        full       <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (in_valid && !finish) begin
                        if (w_legal) begin
                            im_wdata    <= w_word;
`ifdef DELAY_SLOT_NOP_EN
                            r_is_branch <= w_branch;
`endif
                        end else begin
                            err_illegal <= 1'b1;
                        end
                    end
                end
                WRITE,
`ifdef DELAY_SLOT_NOP_EN
                WRITE_NOP,
`endif
                FULL: begin
                    if (state_q != FULL) begin
                        word_count <= word_count + c_cnt_one;
                        if (im_addr == c_last_addr) full <= 1'b1;
                        else                        im_addr <= im_addr + c_addr_one;
`ifdef DELAY_SLOT_NOP_EN
                        // The delay-slot word that follows a branch is an all-zero NOP
                        if ((state_q == WRITE) && r_is_branch) im_wdata <= 32'd0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder_loader
// Purpose  : Self-checking bench for instr_encoder_loader. A driver issues
//            handshakes and pushes expected memory writes / error pulses into
//            a scoreboard; a monitor pops and compares on every DUT output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder_loader;

    localparam int AW = 5;
    localparam logic [AW-1:0] LAST = '1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          finish = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [5:0]    op_sel = '0;
    logic [4:0]    rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [15:0]   imm = '0;
    logic [25:0]   target = '0;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          busy, full, err_illegal;
    logic [AW:0]   word_count;

    instr_encoder_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .finish(finish), .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .imm(imm), .target(target), .im_we(im_we), .im_addr(im_addr),
        .im_wdata(im_wdata), .busy(busy), .full(full),
        .err_illegal(err_illegal), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit            is_err;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [AW:0]   cnt;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    int            n_vec = 0;
    int            n_bad = 0;
    logic [AW-1:0] m_addr = '0;
    logic [AW:0]   m_cnt = '0;
    bit            m_full = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference encoder built from opcode/funct tables
    function automatic logic [31:0] ref_enc(input int op, input logic [4:0] s, input logic [4:0] t,
                                            input logic [4:0] d, input logic [4:0] sh,
                                            input logic [15:0] im, input logic [25:0] tg);
        logic [5:0] rfun [0:16];
        logic [5:0] iop  [0:13];
        rfun = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};
        iop  = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B, 6'h0F, 6'h23,
                 6'h2B, 6'h04, 6'h05, 6'h06, 6'h07};
        if (op <= 9 || (op >= 13 && op <= 15)) return {6'h00, s, t, d, 5'd0, rfun[op]};
        if (op <= 12) return {11'd0, t, d, sh, rfun[op]};
        if (op == 16) return {6'h00, s, 15'd0, rfun[op]};
        if (op <= 30) return {iop[op-17], (op == 24) ? 5'd0 : s,
                              (op == 29 || op == 30) ? 5'd0 : t, im};
        if (op <= 32) return {6'h01, s, (op == 32) ? 5'd1 : 5'd0, im};
        if (op == 33) return {6'h02, tg};
        return {6'h1C, s, t, d, 5'd0, (op == 35) ? 6'h21 : 6'h20};
    endfunction

    function automatic void push_write(input logic [31:0] w, input int c);
        sb.push_back('{1'b0, m_addr, w, m_cnt, c});
        m_cnt = m_cnt + 1'b1;
        if (m_addr == LAST) m_full = 1'b1;
        else                m_addr = m_addr + 1'b1;
    endfunction

    function automatic void model_accept(input int op, input logic [31:0] w);
        if (op >= 36) begin
            sb.push_back('{1'b1, m_addr, 32'd0, m_cnt, cyc});
        end else begin
            push_write(w, cyc);
`ifdef DELAY_SLOT_NOP_EN
            if ((op == 16 || (op >= 27 && op <= 33)) && !m_full) push_write(32'd0, cyc + 1);
`endif
        end
    endfunction

    task automatic send(input int op, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                        input logic [4:0] sh, input logic [15:0] im, input logic [25:0] tg,
                        input bit use_exp, input logic [31:0] exp_word);
        bit rdy = 1'b0;
        op_sel = 6'(op); rs = s; rt = t; rd = d; shamt = sh; imm = im; target = tg;
        in_valid = 1'b1;
        for (int i = 0; i < 40 && !rdy; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
        chk("handshake", rdy, 1'b1);
        if (rdy) model_accept(op, use_exp ? exp_word : ref_enc(op, s, t, d, sh, im, tg));
    endtask

    task automatic send_rand(input int op);
        send(op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             16'($urandom), 26'($urandom), 1'b0, 32'd0);
    endtask

    task automatic do_start(input logic [AW-1:0] b);
        start = 1'b1; base_addr = b;
        @(posedge clk);
        #1 start = 1'b0;
        m_addr = b; m_cnt = '0; m_full = 1'b0;
        chk("start_busy", busy, 1'b1);
        chk("start_addr", im_addr, b);
        chk("start_count", word_count, 0);
        chk("start_full", full, 1'b0);
    endtask

    // Ends the session, sometimes with a competing in_valid that must be dropped
    task automatic do_finish();
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready || full;
        end
        chk("finish_reachable", ok, 1'b1);
        finish = 1'b1;
        in_valid = 1'($urandom_range(0, 1));
        op_sel = 6'($urandom_range(0, 63));
        @(posedge clk);
        #1 finish = 1'b0; in_valid = 1'b0;
        chk("busy_after_finish", busy, 1'b0);
    endtask

    task automatic stray_start();
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
        end
        start = 1'b1; base_addr = ~m_addr;
        @(posedge clk);
        #1 start = 1'b0;
        chk("stray_start_addr", im_addr, m_addr);
        chk("stray_start_count", word_count, m_cnt);
    endtask

    // Monitor: every write or error pulse must match the next scoreboard entry
    always @(negedge clk) begin
        exp_t e;
        if (im_we || err_illegal) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {im_we, err_illegal}, 2'b00);
            end else begin
                e = sb.pop_front();
                chk("out_kind", {im_we, err_illegal}, e.is_err ? 2'b01 : 2'b10);
                chk("out_cycle", cyc, e.cyc);
                chk("out_word_count", word_count, e.cnt);
                if (!e.is_err) begin
                    chk("im_addr", im_addr, e.addr);
                    chk("im_wdata", im_wdata, e.data);
                    chk("in_ready_during_write", in_ready, 1'b0);
                end else begin
                    chk("in_ready_on_err", in_ready, 1'b1);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_im_we", im_we, 0);
        chk("rst_im_addr", im_addr, 0);
        chk("rst_im_wdata", im_wdata, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_full", full, 0);
        chk("rst_err", err_illegal, 0);
        chk("rst_word_count", word_count, 0);
        rst_n = 1'b1;

        // add at base 0x10
        do_start(5'h10);
        send(0, 5'd1, 5'd2, 5'd3, 5'h1F, 16'hFFFF, 26'h3FFFFFF, 1'b1, 32'h00221820);
        do_finish();

        // addi then lw at base 0; unused fields driven with ones
        do_start(5'h00);
        send(17, 5'd0, 5'd1, 5'h1F, 5'h1F, 16'h0005, 26'h3FFFFFF, 1'b1, 32'h20010005);
        send(25, 5'd29, 5'd8, 5'h1F, 5'h1F, 16'h0004, 26'h3FFFFFF, 1'b1, 32'h8FA80004);
        // j and bgez (rt input must not leak)
        send(33, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 16'hFFFF, 26'h0000010, 1'b1, 32'h08000010);
        send(32, 5'd4, 5'h1F, 5'h1F, 5'h1F, 16'hFFFE, 26'h3FFFFFF, 1'b1, 32'h0481FFFE);
        // illegal op: error pulse only
        send_rand(40);
        send_rand(63);
        send_rand(12);
        do_finish();

        // Fill to the last address; further fields are refused
        do_start(LAST - 1'b1);
        send_rand(0);
        send_rand(2);
        repeat (2) @(posedge clk);
        #1;
        chk("full_set", full, 1'b1);
        chk("full_count", word_count, 2);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("full_in_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        do_finish();
        chk("full_held_in_idle", full, 1'b1);

        // Branch at the last address, then branch one before it
        do_start(LAST);
        send_rand(33);
        do_finish();
        chk("full_after_last_branch", full, 1'b1);
        do_start(LAST - 1'b1);
        send_rand(27);
        repeat (3) @(posedge clk);
        #1;
        chk("branch_near_end_count", word_count, m_cnt);
        chk("branch_near_end_full", full, m_full);
        do_finish();

        // Reset while a word is being written
        do_start(5'd5);
        send(0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b1, 32'h00221820);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_im_we", im_we, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_im_addr", im_addr, 0);
        chk("midrst_count", word_count, 0);
        chk("midrst_wdata", im_wdata, 0);
        rst_n = 1'b1;

        // Randomized sessions
        for (int s = 0; s < 10; s++) begin
            int n;
            do_start(AW'($urandom));
            n = $urandom_range(3, 16);
            for (int k = 0; k < n; k++) begin
                int r;
                if (m_full) break;
                r = $urandom_range(0, 19);
                if (r == 0)      send_rand($urandom_range(36, 63));
                else if (r == 1) begin repeat ($urandom_range(1, 3)) @(posedge clk); #1; end
                else if (r == 2) stray_start();
                else             send_rand($urandom_range(0, 35));
            end
            do_finish();
            chk("session_count", word_count, m_cnt);
        end

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encoding counterpart of the MIPS control decoder: takes symbolic instruction fields over a valid/ready handshake and builds 32-bit MIPS instruction words.
- Writes each word into instruction memory through its write port, at consecutive word addresses from a programmable base.
- Used by the bench and the boot path to load programs into the single-cycle CPU's instruction memory.
- Supports exactly the instruction set the CPU decodes.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; last valid address is 2^ADDR_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load session at base_addr.
- base_addr  in  ADDR_W  first word address of the session.
- finish  in  1  one-cycle pulse; ends the session.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  encoder can accept fields.
- op_sel  in  6  instruction select (enumeration below).
- rs, rt, rd, shamt  in  5 each  register and shift fields.
- imm  in  16  immediate or branch offset.
- target  in  26  jump target field.
- im_we  out  1  instruction-memory write enable.
- im_addr  out  ADDR_W  write word address.
- im_wdata  out  32  encoded instruction.
- busy  out  1  session active (not IDLE).
- full  out  1  last address has been written.
- err_illegal  out  1  one-cycle pulse when an illegal op_sel is accepted.
- word_count  out  ADDR_W+1  words written this session.

Behaviour:
- op_sel encoding, given as op_sel: mnemonic(funct or opcode):
  - R-type, opcode 0: 0:add(20), 1:addu(21), 2:sub(22), 3:subu(23), 4:and(24), 5:or(25), 6:xor(26), 7:nor(27), 8:slt(2A), 9:sltu(2B), 10:sll(00), 11:srl(02), 12:sra(03), 13:sllv(04), 14:srlv(06), 15:srav(07), 16:jr(08).
  - I-type: 17:addi(08), 18:addiu(09), 19:andi(0C), 20:ori(0D), 21:xori(0E), 22:slti(0A), 23:sltiu(0B), 24:lui(0F), 25:lw(23), 26:sw(2B), 27:beq(04), 28:bne(05), 29:blez(06), 30:bgtz(07).
  - REGIMM, opcode 01: 31:bltz (rt=0), 32:bgez (rt=1).
  - Jump: 33:j(02).
  - Opcode 1C: 34:clz (funct 20), 35:clo (funct 21).
  - op_sel >= 36 is illegal.
- Field forcing:
  - shamt is 0 for every instruction except sll, srl and sra.
  - rs is 0 for sll, srl, sra and lui.
  - rt, rd and shamt are 0 for jr.
  - rt is 0 for blez and bgtz.
  - rt is hardwired for bltz and bgez.
  - All unused fields are 0; no input bit leaks into a forced-zero field.
- FSM states: IDLE, ACCEPT, WRITE, FULL.
  - IDLE: in_ready=0. start → ACCEPT; im_addr<=base_addr; word_count<=0; full<=0.
  - ACCEPT: in_ready=1.
    - in_valid with a legal op: encode, latch im_wdata, go to WRITE.
    - in_valid with an illegal op: err_illegal=1 for one cycle, no write, stay in ACCEPT.
    - finish → IDLE.
    - finish has priority over a same-cycle in_valid; those fields are dropped.
  - WRITE: im_we=1 for exactly one cycle at im_addr; word_count increments.
    - If im_addr == 2^ADDR_W-1: full<=1, go to FULL, im_addr holds.
    - Otherwise im_addr increments and the FSM returns to ACCEPT.
  - FULL: in_ready=0; only finish → IDLE (full stays 1 until the next start).
- Timing:
  - Latency is handshake cycle N → im_we at N+1.
  - Maximum throughput is 1 word per 2 cycles.
- start outside IDLE is ignored.
- Reset (rst_n=0 at a clock edge, including mid-session) forces: state=IDLE, im_we=0, im_addr=0, im_wdata=0, in_ready=0, busy=0, full=0, err_illegal=0, word_count=0.
- Any pending word is discarded on reset.
- busy=1 whenever state ≠ IDLE.

Optional Feature:
- Macro: DELAY_SLOT_NOP_EN.
- When defined:
  - Adds state WRITE_NOP.
  - After WRITE of any branch/jump (ops 16, 27–33), the FSM writes 0x00000000 at the next address in the following cycle, then returns to ACCEPT.
  - word_count counts both words.
  - If the branch lands at the last address, no NOP is written and full is asserted.
  - If the NOP lands at the last address, full is asserted after the NOP.
- When undefined: no NOP insertion; branch ops behave like any other op.

Test Plan:
- start, base 0x10; add rd=3 rs=1 rt=2 → im_we one cycle after the handshake, im_addr 0x10, im_wdata 0x00221820, word_count 1.
- addi rt=1 rs=0 imm=5, then lw rt=8 rs=29 imm=4 → 0x20010005 at 0x00, 0x8FA80004 at 0x01; in_ready low during each WRITE.
- j target=0x10, then bgez rs=4 imm=0xFFFE → 0x08000010, then 0x0481FFFE; with DELAY_SLOT_NOP_EN, 0x00000000 is written after each.
- op_sel=40 with in_valid → err_illegal pulse, no im_we, in_ready stays 1, word_count unchanged.
- ADDR_W=2, base 2; three valid words → writes at 2 and 3, full=1, third word never accepted (in_ready=0); finish → IDLE.
- rst_n low during WRITE → next cycle im_we=0, busy=0, im_addr=0, word_count=0.
